// File: rtl/ps2_key_decoder.sv
// ---------------------------------------------------------------------------
// ps2_key_decoder
//   Receive-only PS/2 keyboard decoder. Synchronizes the raw PS/2 clock and
//   data lines, frames 11-bit words (start, 8 data LSB first, odd parity,
//   stop), and runs a prefix tracker that turns scan-code bytes into make
//   codes. Break sequences (F0 xx, E0 F0 xx) are swallowed silently.
//
// Parameters
//   TIMEOUT      idle iCLK cycles after which a partial frame is discarded
//   SYNC_STAGES  synchronizer depth for ps2_clk / ps2_data (>= 2)
//
// Ports
//   iCLK       in   system clock, rising edge
//   iRST       in   asynchronous active-high reset
//   ps2_clk    in   raw PS/2 clock (asynchronous)
//   ps2_data   in   raw PS/2 data  (asynchronous)
//   key_in     out  last make code (E0-prefixed codes give the base byte)
//   key_en     out  one-cycle strobe: new make code on key_in
//   key_ext    out  make code was E0-prefixed
//   frame_err  out  one-cycle strobe: start/parity/stop/timeout error
// ---------------------------------------------------------------------------
module ps2_key_decoder #(
  parameter int TIMEOUT     = 25000,
  parameter int SYNC_STAGES = 2
) (
  input  logic       iCLK,
  input  logic       iRST,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] key_in,
  output logic       key_en,
  output logic       key_ext,
  output logic       frame_err
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} frame_state_t;
  typedef enum logic [1:0] {P_NORM, P_E0, P_F0, P_E0F0} prefix_state_t;

  logic [SYNC_STAGES-1:0] r_clk_sync;
  logic [SYNC_STAGES-1:0] r_data_sync;
  logic                   r_clk_prev;
  frame_state_t           r_state;
  prefix_state_t          r_prefix;
  logic [2:0]             r_bit_cnt;
  logic [7:0]             r_shift;
  logic                   r_parity;
  logic [TW-1:0]          r_to_cnt;

  logic w_clk_s;
  logic w_data_s;
  logic w_fall;
  logic w_frame_ok;

  assign w_clk_s    = r_clk_sync[SYNC_STAGES-1];
  assign w_data_s   = r_data_sync[SYNC_STAGES-1];
  assign w_fall     = r_clk_prev & ~w_clk_s;
  // Stop bit high and odd parity over data+parity.
  assign w_frame_ok = w_data_s & (^r_shift ^ r_parity);

  // Idle PS/2 lines are high, so the synchronizer resets to 1; this keeps a
  // reset release from looking like a falling edge.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      r_clk_sync  <= '1;
      r_data_sync <= '1;
      r_clk_prev  <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments make every flop sample the old value
      // of its neighbour, which is what turns this into a shift chain.
      r_clk_sync  <= {r_clk_sync[SYNC_STAGES-2:0], ps2_clk};
      r_data_sync <= {r_data_sync[SYNC_STAGES-2:0], ps2_data};
      r_clk_prev  <= w_clk_s;
    end
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      r_state   <= S_IDLE;
      r_prefix  <= P_NORM;
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_parity  <= 1'b0;
      r_to_cnt  <= '0;
      key_in    <= 8'h00;
      key_en    <= 1'b0;
      key_ext   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      key_en    <= 1'b0;
      frame_err <= 1'b0;

      // Watchdog: only runs while a frame is in progress.
      if (r_state == S_IDLE || w_fall) begin
        r_to_cnt <= '0;
      end else begin
        r_to_cnt <= r_to_cnt + 1'b1;
      end

      if (w_fall) begin
        unique case (r_state)
          S_IDLE: begin
            if (!w_data_s) begin
              r_state   <= S_DATA;
              r_bit_cnt <= '0;
            end
          end
          S_DATA: begin
            r_shift[r_bit_cnt] <= w_data_s;
            r_bit_cnt          <= r_bit_cnt + 1'b1;
            if (r_bit_cnt == 3'd7) r_state <= S_PARITY;
          end
          S_PARITY: begin
            r_parity <= w_data_s;
            r_state  <= S_STOP;
          end
          S_STOP: begin
            r_state <= S_IDLE;
            if (!w_frame_ok) begin
              frame_err <= 1'b1;
            end else begin
              unique case (r_prefix)
                P_F0, P_E0F0: r_prefix <= P_NORM;  // byte after F0 is a break code
                default: begin
                  if (r_shift == 8'hE0) begin
                    r_prefix <= P_E0;
                  end else if (r_shift == 8'hF0) begin
                    r_prefix <= (r_prefix == P_E0) ? P_E0F0 : P_F0;
                  end else begin
                    key_in   <= r_shift;
                    key_en   <= 1'b1;
                    key_ext  <= (r_prefix == P_E0);
                    r_prefix <= P_NORM;
                  end
                end
              endcase
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end else if (r_state != S_IDLE && r_to_cnt == TW'(TIMEOUT - 1)) begin
        // TIMEOUT cycles without an edge: abandon the frame and the prefix.
        r_state   <= S_IDLE;
        r_prefix  <= P_NORM;
        frame_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ps2_key_decoder.sv
module tb_ps2_key_decoder;

  localparam int TIMEOUT = 100;
  localparam int SYNC    = 2;
  localparam int HP      = 8;   // PS/2 half-period in iCLK cycles

  logic       iCLK = 1'b0;
  logic       iRST;
  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] key_in;
  logic       key_en;
  logic       key_ext;
  logic       frame_err;

  ps2_key_decoder #(.TIMEOUT(TIMEOUT), .SYNC_STAGES(SYNC)) dut (
    .iCLK(iCLK), .iRST(iRST), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .key_in(key_in), .key_en(key_en), .key_ext(key_ext), .frame_err(frame_err)
  );

  always #5 iCLK = ~iCLK;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model: bytes in, make codes out -------------
  logic [8:0] exp_q[$];      // {ext, code}
  int         exp_err = 0;
  bit         m_ext   = 0;   // an E0 is pending
  bit         m_brk   = 0;   // next byte is the tail of a break sequence

  function automatic void model_byte(input logic [7:0] b);
    if (m_brk) begin
      m_brk = 0;
      m_ext = 0;
    end else if (b == 8'hF0) begin
      m_brk = 1;
    end else if (b == 8'hE0) begin
      m_ext = 1;
    end else begin
      exp_q.push_back({m_ext, b});
      m_ext = 0;
    end
  endfunction

  function automatic void model_clear();
    m_ext = 0;
    m_brk = 0;
  endfunction

  // ---------------- monitor ----------------------------------------------
  logic [8:0] obs_q[$];
  int         obs_err = 0;
  logic       prev_en = 0, prev_err = 0;

  always @(negedge iCLK) begin
    if (!iRST) begin
      if (key_en) begin
        obs_q.push_back({key_ext, key_in});
        check("key_en_width", {31'd0, prev_en}, 32'd0);
      end
      if (frame_err) begin
        obs_err++;
        check("frame_err_width", {31'd0, prev_err}, 32'd0);
      end
    end
    prev_en  = key_en;
    prev_err = frame_err;
  end

  // ---------------- stimulus helpers --------------------------------------
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge iCLK);
      #1;
    end
  endtask

  function automatic logic [10:0] make_frame(input logic [7:0] b, input bit bad_par,
                                             input bit bad_stop);
    logic par;
    par = ~(^b) ^ bad_par;
    return {~bad_stop, par, b, 1'b0};
  endfunction

  // Sends bits[0..n-1]; optionally checks key_en latency on the 11th bit.
  task automatic send_bits(input logic [10:0] bits, input int n, input bit lat_chk);
    for (int i = 0; i < n; i++) begin
      ps2_data = bits[i];
      tick(HP);
      ps2_clk = 1'b0;
      if (lat_chk && i == 10) begin
        for (int c = 1; c <= HP; c++) begin
          tick(1);
          if (c == SYNC)     check("latency_early", {31'd0, key_en}, 32'd0);
          if (c == SYNC + 1) check("latency_en",    {31'd0, key_en}, 32'd1);
        end
      end else begin
        tick(HP);
      end
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    tick(2 * HP);
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_bits(make_frame(b, 1'b0, 1'b0), 11, 1'b0);
    model_byte(b);
  endtask

  task automatic compare(input string tag);
    logic [8:0] o, e;
    tick(4);
    check({tag, "_nkeys"}, obs_q.size(), exp_q.size());
    check({tag, "_nerr"}, obs_err, exp_err);
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      check({tag, "_key"}, {23'd0, o}, {23'd0, e});
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_key_in"},    {24'd0, key_in},    32'd0);
    check({tag, "_key_en"},    {31'd0, key_en},    32'd0);
    check({tag, "_key_ext"},   {31'd0, key_ext},   32'd0);
    check({tag, "_frame_err"}, {31'd0, frame_err}, 32'd0);
  endtask

  initial begin
    #(60000 * 10);
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  // ---------------- main sequence ----------------------------------------
  initial begin
    int saved_err;
    logic [7:0] b;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    iRST     = 1'b1;
    tick(4);
    check_reset_outputs("reset");
    iRST = 1'b0;
    tick(5);

    // Single make code with latency measurement.
    send_bits(make_frame(8'h1C, 1'b0, 1'b0), 11, 1'b1);
    model_byte(8'h1C);
    compare("make_1c");

    // Extended make, then extended break.
    send_byte(8'hE0); send_byte(8'h72);
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h72);
    compare("ext");

    // Break then make of the same key.
    send_byte(8'hF0); send_byte(8'h1C); send_byte(8'h1C);
    compare("break");

    // Parity error must leave key_in alone.
    send_byte(8'h2A);
    send_bits(make_frame(8'h1C, 1'b1, 1'b0), 11, 1'b0);
    exp_err++;
    compare("parity");
    check("parity_hold_key", {24'd0, key_in}, 32'h2A);

    // Stop-bit error.
    send_bits(make_frame(8'h4D, 1'b0, 1'b1), 11, 1'b0);
    exp_err++;
    compare("stop");

    // Timeout on a partial frame; E0 pending before it must be forgotten.
    send_byte(8'hE0);
    saved_err = obs_err;
    send_bits(make_frame(8'h00, 1'b0, 1'b0), 5, 1'b0);
    tick(TIMEOUT / 2 - 2 * HP);
    check("timeout_early", obs_err, saved_err);
    for (int i = 0; i < 2 * TIMEOUT && obs_err == saved_err; i++) tick(1);
    exp_err++;
    model_clear();
    send_byte(8'h6B);
    compare("timeout");

    // Reset in the middle of a frame; its tail must be ignored.
    send_byte(8'h33);
    compare("pre_reset");
    send_bits(make_frame(8'hF0, 1'b0, 1'b0), 5, 1'b0);
    iRST = 1'b1;
    tick(1);
    check_reset_outputs("mid_reset");
    tick(3);
    iRST = 1'b0;
    model_clear();
    tick(3);
    send_bits(make_frame(8'hF0, 1'b0, 1'b0) >> 5, 6, 1'b0);
    compare("reset_tail");
    send_byte(8'h74);
    compare("post_reset");

    // Random byte stream with occasional prefixes and corrupted frames.
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 7))
        0:       b = 8'hE0;
        1:       b = 8'hF0;
        2:       b = 8'hFA;
        default: b = 8'($urandom);
      endcase
      if ($urandom_range(0, 9) == 0) begin
        send_bits(make_frame(b, 1'b1, $urandom_range(0, 1) == 1), 11, 1'b0);
        exp_err++;
      end else begin
        send_byte(b);
      end
      if (i % 10 == 9) compare("random");
    end
    compare("random_end");

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
